led_ram_port_arbiter: RTL and testbench

- Shares the second (s2) port of the 2048x32 LED colour on-chip RAM between two masters.
  - Master 0: zone-colour writer from the VGA averaging pipeline.
  - Master 1: LED strip streamer, which reads.
- Single-word transactions, round-robin arbitration.
- Optional lock for short bursts, bounded by a starvation limit.
- Generates read-data-valid strobes from the RAM's fixed 1-cycle read latency (registered address, unregistered q).

---
 rtl/led_ram_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_led_ram_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_ram_port_arbiter.sv
// Round-robin arbiter sharing the s2 port of the 2048x32 LED colour RAM between
// the zone-colour writer (m0) and the LED strip streamer (m1). Optional perf counters: LED_RAM_ARB_PERF_EN.
module led_ram_port_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          m0_req,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_be,
  input  logic          m0_lock,
  output logic          m0_ack,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_be,
  input  logic          m1_lock,
  output logic          m1_ack,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic [AW-1:0] mem_address,
  output logic          mem_chipselect,
  output logic          mem_write,
  output logic [DW-1:0] mem_writedata,
  output logic [3:0]    mem_byteenable,
  output logic          mem_clken,
  input  logic [DW-1:0] mem_readdata,

  output logic [1:0]    owner_state
`ifdef LED_RAM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_grant0,
  output logic [31:0]   perf_grant1,
  output logic [31:0]   perf_conflict
`endif
);

  // Handshake: a master holds req and its command fields stable until it sees
  // ack in the same cycle; a read returns rvalid/rdata exactly one cycle later.

  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          last_grant_q;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic [AW-1:0] addr_q;
  logic          rvalid0_q;
  logic          rvalid1_q;

  logic          own0;
  logic          own1;
  logic          grant0;
  logic          grant1;
  logic          any_grant;
  logic          g_lock;
  logic          o_req;
  logic          cont;
  logic [HW-1:0] eff_hold;

  // An owner only keeps priority while it is still requesting.
  assign own0      = (state_q == ST_OWN0) && m0_req;
  assign own1      = (state_q == ST_OWN1) && m1_req;
  assign any_grant = grant0 || grant1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (own0) begin
        grant0 = 1'b1;
      end else if (own1) begin
        grant1 = 1'b1;
      end else if (m0_req && m1_req) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else if (m0_req) begin
        grant0 = 1'b1;
      end else if (m1_req) begin
        grant1 = 1'b1;
      end
    end
  end

  // Lock keeps ownership; the starvation limit forces a return to IDLE so the
  // other master wins the following tie via last_grant.
  always_comb begin
    state_d  = ST_IDLE;
    hold_d   = '0;
    g_lock   = grant0 ? m0_lock : m1_lock;
    o_req    = grant0 ? m1_req : m0_req;
    cont     = (grant0 && own0) || (grant1 && own1);
    eff_hold = cont ? hold_q : '0;
    if (any_grant && g_lock && !(o_req && (eff_hold >= HOLD_LIM))) begin
      state_d = grant0 ? ST_OWN0 : ST_OWN1;
      if (o_req) begin
        hold_d = (eff_hold == '1) ? eff_hold : eff_hold + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      hold_q       <= '0;
      addr_q       <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rvalid0_q <= grant0 && !m0_write;
      rvalid1_q <= grant1 && !m1_write;
      if (any_grant) begin
        last_grant_q <= grant1;
        addr_q       <= mem_address;
      end
    end
  end

  assign m0_ack = grant0;
  assign m1_ack = grant1;

  // A read accepted just before reset must not surface during the reset cycle.
  assign m0_rvalid = rvalid0_q && !reset;
  assign m1_rvalid = rvalid1_q && !reset;
  assign m0_rdata  = mem_readdata;
  assign m1_rdata  = mem_readdata;

  assign mem_chipselect = any_grant;
  assign mem_write      = (grant0 && m0_write) || (grant1 && m1_write);
  assign mem_address    = grant0 ? m0_addr : (grant1 ? m1_addr : (reset ? '0 : addr_q));
  assign mem_writedata  = grant0 ? m0_wdata : (grant1 ? m1_wdata : '0);
  assign mem_byteenable = grant0 ? m0_be : (grant1 ? m1_be : 4'h0);
  assign mem_clken      = 1'b1;

  assign owner_state = state_q;

`ifdef LED_RAM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      perf_grant0   <= perf_grant0 + {31'd0, grant0};
      perf_grant1   <= perf_grant1 + {31'd0, grant1};
      perf_conflict <= perf_conflict + {31'd0, (m0_req && m1_req)};
    end
  end
`endif

endmodule

// File: tb/tb_led_ram_port_arbiter.sv
// Bench for led_ram_port_arbiter: directed steps plus random traffic checked
// every cycle against a rule-level arbitration and memory model.
module tb_led_ram_port_arbiter;
  localparam int AW       = 11;
  localparam int DW       = 32;
  localparam int MAX_HOLD = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_write, m0_lock, m0_ack, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [3:0]    m0_be;
  logic          m1_req, m1_write, m1_lock, m1_ack, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [3:0]    m1_be;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic [3:0]    mem_byteenable;
  logic [1:0]    owner_state;
`ifdef LED_RAM_ARB_PERF_EN
  logic [31:0]   perf_grant0, perf_grant1, perf_conflict;
`endif

  led_ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .owner_state(owner_state)
`ifdef LED_RAM_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM port model: registered address, unregistered q
  logic [DW-1:0] ram [0:2047];
  logic [AW-1:0] ram_addr_q;
  assign mem_readdata = ram[ram_addr_q];
  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = '0;
    ram_addr_q = '0;
    forever begin
      @(posedge clk);
      if (mem_chipselect && mem_clken) begin
        if (mem_write)
          for (int b = 0; b < 4; b++)
            if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
        ram_addr_q <= mem_address;
      end
    end
  end

  // reference model + scoreboard
  logic [DW-1:0] exp_mem [0:2047];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            mdl_last, mdl_owner, mdl_streak;
  logic [AW-1:0] mdl_addr;
  int            tests = 0;
  int            fails = 0;
  logic          o_ack0, o_ack1, o_rv0, o_rv1, o_cs, o_wr;
  logic [DW-1:0] o_rdata0, o_rdata1;
  logic [AW-1:0] o_addr;
  logic [3:0]    o_be;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_m0(input logic rq, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] be, input logic lk);
    m0_req = rq; m0_write = wr; m0_addr = a; m0_wdata = d; m0_be = be; m0_lock = lk;
  endtask

  task automatic set_m1(input logic rq, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] be, input logic lk);
    m1_req = rq; m1_write = wr; m1_addr = a; m1_wdata = d; m1_be = be; m1_lock = lk;
  endtask

  task automatic rand_txn(input int m);
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    be;
    wr = 1'($urandom_range(0, 1));
    a  = AW'($urandom_range(0, 15));
    d  = $urandom();
    be = 4'($urandom_range(0, 15));
    if (m == 0) set_m0(1'b1, wr, a, d, be, m0_lock);
    else        set_m1(1'b1, wr, a, d, be, m1_lock);
  endtask

  // One clock cycle: check DUT against the model at the negedge, then advance the model.
  task automatic step();
    int            g;
    int            oreq;
    logic          rq [2];
    logic          wr [2];
    logic          lk [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic [3:0]    be [2];
    @(negedge clk);
    rq[0] = m0_req; wr[0] = m0_write; lk[0] = m0_lock; ad[0] = m0_addr; wd[0] = m0_wdata; be[0] = m0_be;
    rq[1] = m1_req; wr[1] = m1_write; lk[1] = m1_lock; ad[1] = m1_addr; wd[1] = m1_wdata; be[1] = m1_be;
    if (reset)                             g = -1;
    else if (mdl_owner >= 0 && rq[mdl_owner]) g = mdl_owner;
    else if (rq[0] && rq[1])               g = 1 - mdl_last;
    else if (rq[0])                        g = 0;
    else if (rq[1])                        g = 1;
    else                                   g = -1;

    check_bit("ack0", m0_ack, g == 0);
    check_bit("ack1", m1_ack, g == 1);
    check_bit("chipselect", mem_chipselect, g >= 0);
    check_bit("clken", mem_clken, 1'b1);
    check_bit("owner_busy", owner_state != 2'd0, mdl_owner >= 0);
    if (g >= 0) begin
      check_bit("mem_write", mem_write, wr[g]);
      check_word("mem_addr", 32'(mem_address), 32'(ad[g]));
      check_word("mem_be", 32'(mem_byteenable), 32'(be[g]));
      if (wr[g]) check_word("mem_wdata", mem_writedata, wd[g]);
    end else begin
      check_bit("mem_write_idle", mem_write, 1'b0);
      check_word("mem_addr_hold", 32'(mem_address), reset ? 32'd0 : 32'(mdl_addr));
    end

    if (!reset && exp_q0.size() > 0) begin
      check_bit("rvalid0", m0_rvalid, 1'b1);
      check_word("rdata0", m0_rdata, exp_q0.pop_front());
    end else begin
      check_bit("rvalid0_idle", m0_rvalid, 1'b0);
    end
    if (!reset && exp_q1.size() > 0) begin
      check_bit("rvalid1", m1_rvalid, 1'b1);
      check_word("rdata1", m1_rdata, exp_q1.pop_front());
    end else begin
      check_bit("rvalid1_idle", m1_rvalid, 1'b0);
    end

    o_ack0 = m0_ack; o_ack1 = m1_ack; o_rv0 = m0_rvalid; o_rv1 = m1_rvalid;
    o_rdata0 = m0_rdata; o_rdata1 = m1_rdata; o_cs = mem_chipselect; o_wr = mem_write;
    o_addr = mem_address; o_be = mem_byteenable;

    if (reset) begin
      mdl_last = 1; mdl_owner = -1; mdl_streak = 0; mdl_addr = '0;
      exp_q0.delete(); exp_q1.delete();
    end else if (g < 0) begin
      mdl_owner = -1; mdl_streak = 0;
    end else begin
      if (wr[g]) begin
        for (int b = 0; b < 4; b++)
          if (be[g][b]) exp_mem[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
      end else if (g == 0) begin
        exp_q0.push_back(exp_mem[ad[g]]);
      end else begin
        exp_q1.push_back(exp_mem[ad[g]]);
      end
      oreq = int'(rq[1-g]);
      if (mdl_owner == g) mdl_streak = (oreq != 0) ? mdl_streak + 1 : 0;
      else                mdl_streak = (oreq != 0) ? 1 : 0;
      mdl_owner = (lk[g] && !(oreq != 0 && mdl_streak >= MAX_HOLD)) ? g : -1;
      mdl_last  = g;
      mdl_addr  = ad[g];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) exp_mem[i] = '0;
    mdl_last = 1; mdl_owner = -1; mdl_streak = 0; mdl_addr = '0;
    reset = 1'b1;
    set_m0(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    set_m1(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    step();
    step();
    reset = 1'b0;

    // write then read of the same word, m0 wins the first tie
    set_m0(1'b1, 1'b1, 11'h005, 32'hA1B2C3D4, 4'hF, 1'b0);
    set_m1(1'b1, 1'b0, 11'h005, '0, 4'hF, 1'b0);
    step();
    check_bit("t1_m0_ack_c1", o_ack0, 1'b1);
    check_bit("t1_m1_wait_c1", o_ack1, 1'b0);
    m0_req = 1'b0;
    step();
    check_bit("t1_m1_ack_c2", o_ack1, 1'b1);
    m1_req = 1'b0;
    step();
    check_bit("t1_m1_rvalid_c3", o_rv1, 1'b1);
    check_word("t1_m1_rdata_c3", o_rdata1, 32'hA1B2C3D4);

    // both requesting without lock alternates
    set_m0(1'b1, 1'b0, 11'h005, '0, 4'hF, 1'b0);
    set_m1(1'b1, 1'b0, 11'h006, '0, 4'hF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_bit("t2_alt_m0", o_ack0, (i % 2) == 0);
      check_bit("t2_alt_m1", o_ack1, (i % 2) == 1);
    end
    set_m0(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    set_m1(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    step();

    // locked m0 is cut off after MAX_HOLD grants
    set_m0(1'b1, 1'b0, 11'h010, '0, 4'hF, 1'b1);
    set_m1(1'b1, 1'b0, 11'h020, '0, 4'hF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_bit("t3_hold_m0", o_ack0, (i < MAX_HOLD) || (i == MAX_HOLD + 1));
      check_bit("t3_hold_m1", o_ack1, i == MAX_HOLD);
    end
    set_m0(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    set_m1(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    step();

    // partial byte-enable write at the top word, then the bottom word
    set_m0(1'b1, 1'b1, 11'h7FF, 32'hFFFFFFFF, 4'hF, 1'b0);
    step();
    set_m0(1'b1, 1'b1, 11'h7FF, 32'h11223344, 4'h3, 1'b0);
    step();
    check_word("t4_be_pass", 32'(o_be), 32'h3);
    set_m0(1'b1, 1'b0, 11'h7FF, '0, 4'hF, 1'b0);
    step();
    set_m0(1'b1, 1'b0, 11'h000, '0, 4'hF, 1'b0);
    step();
    check_bit("t4_rvalid_7ff", o_rv0, 1'b1);
    check_word("t4_rdata_7ff", o_rdata0, 32'hFFFF3344);
    check_word("t4_addr_000", 32'(o_addr), 32'h0);
    set_m0(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    step();

    // read accepted right before reset never produces rvalid
    set_m1(1'b1, 1'b0, 11'h005, '0, 4'hF, 1'b0);
    step();
    check_bit("t5_m1_ack", o_ack1, 1'b1);
    m1_req = 1'b0;
    reset  = 1'b1;
    step();
    check_bit("t5_rvalid_in_reset", o_rv1, 1'b0);
    reset = 1'b0;
    step();
    check_bit("t5_post_rvalid1", o_rv1, 1'b0);
    check_bit("t5_post_cs", o_cs, 1'b0);
    check_bit("t5_post_write", o_wr, 1'b0);
    check_word("t5_post_addr", 32'(o_addr), 32'h0);
    check_word("t5_post_be", 32'(o_be), 32'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (o_ack0 || !m0_req) begin
        if ($urandom_range(0, 3) != 0) rand_txn(0);
        else m0_req = 1'b0;
      end
      if (o_ack1 || !m1_req) begin
        if ($urandom_range(0, 3) != 0) rand_txn(1);
        else m1_req = 1'b0;
      end
      m0_lock = ($urandom_range(0, 3) != 0);
      m1_lock = ($urandom_range(0, 3) != 0);
      step();
    end
    set_m0(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    set_m1(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    step();

`ifdef LED_RAM_ARB_PERF_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_m0(1'b1, 1'b0, 11'h001, '0, 4'hF, 1'b0);
    set_m1(1'b1, 1'b0, 11'h002, '0, 4'hF, 1'b0);
    for (int i = 0; i < 10; i++) step();
    check_word("perf_grant0", perf_grant0, 32'd5);
    check_word("perf_grant1", perf_grant1, 32'd5);
    check_word("perf_conflict", perf_conflict, 32'd10);
    set_m0(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    set_m1(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
